uart_alu_interface: RTL and testbench
=====================================

# uart_alu_interface

Byte-level controller between the UART receiver/transmitter and the ALU. Collects three consecutive received bytes (operand A, operand B, opcode), presents them to the ALU, captures the result and launches one UART transmission of it. It sits inside the UART top level, between the rx data-valid path and the tx start path, and is the only block that sequences the ALU.

## Interface
- `NB_DATA`, 8, width of UART byte, ALU operands and result
- `NB_OP`, 6, ALU opcode width; taken from the low `NB_OP` bits of the third byte
- `TIMEOUT_CYCLES`, 1_000_000, inter-byte timeout in clock cycles (used only with the timeout macro)
- `NB_TIMEOUT`, `$clog2(TIMEOUT_CYCLES)`, timeout counter width

- `i_clock`  in  1  system clock
- `i_reset`  in  1  asynchronous reset, active-low
- `i_rx_data`  in  NB_DATA  received byte
- `i_rx_data_valid`  in  1  one-cycle pulse, `i_rx_data` valid
- `i_tx_done`  in  1  one-cycle pulse, transmitter finished stop bit
- `i_alu_result`  in  NB_DATA  combinational ALU output
- `o_alu_data_a`  out  NB_DATA  registered operand A
- `o_alu_data_b`  out  NB_DATA  registered operand B
- `o_alu_op`  out  NB_OP  registered opcode
- `o_tx_data`  out  NB_DATA  registered byte to transmit
- `o_tx_start`  out  1  one-cycle transmit request
- `o_busy`  out  1  high from opcode capture until `i_tx_done`
- `o_timeout`  out  1  one-cycle pulse, frame aborted by timeout

## Operation
- States: WAIT_A, WAIT_B, WAIT_OP, LATCH, SEND, WAIT_TX. Reset state WAIT_A.
- WAIT_A: on `i_rx_data_valid`, load `o_alu_data_a`, go to WAIT_B.
- WAIT_B: on valid, load `o_alu_data_b`, go to WAIT_OP.
- WAIT_OP: on valid, load `o_alu_op` with `i_rx_data[NB_OP-1:0]` (upper bits discarded), go to LATCH.
- LATCH: unconditionally `o_tx_data <= i_alu_result`, go to SEND.
- SEND: `o_tx_start` high this cycle only, go to WAIT_TX.
- WAIT_TX: on `i_tx_done`, go to WAIT_A.
- `o_busy` is high in LATCH, SEND and WAIT_TX.
- `i_rx_data_valid` in LATCH, SEND or WAIT_TX is dropped; no buffering.
- `i_tx_done` outside WAIT_TX is ignored.
- Operand and opcode registers hold their values until overwritten; an aborted frame does not clear them.
- Reset values: all outputs 0, all registers 0, state WAIT_A. An `i_reset` assertion at any point, including mid-transmission, returns to WAIT_A at once. The in-flight UART frame is not this block's concern.

## Timing
- Output registers update on the rising edge at which the corresponding valid pulse is sampled.
- Opcode byte sampled at edge N: `o_alu_op` is valid after N, `o_tx_data` is captured at edge N+1, and `o_tx_start` is high during the cycle between edges N+2 and N+3.
- The ALU has one full cycle (WAIT_OP→LATCH) to settle.
- Minimum rx-to-tx_start latency: 2 cycles after the opcode edge.

## Configuration
- Macro: `UART_ALU_IF_TIMEOUT_EN`.
- Defined:
  - A counter runs in WAIT_B and WAIT_OP.
  - It clears on entry to either state and on every `i_rx_data_valid`.
  - It increments otherwise.
  - When it reaches `TIMEOUT_CYCLES-1` with no valid pulse that cycle, the block goes to WAIT_A and pulses `o_timeout` for one cycle.
  - A valid pulse coincident with expiry wins: the byte is accepted and no timeout occurs.
- Undefined: no counter is built, `o_timeout` is tied to 0, and the block waits indefinitely for the next byte.

## Structure
- Shared package `uart_alu_pkg`:
  - state encoding constants
  - default `NB_DATA` / `NB_OP`
  - ALU opcode constants (ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, SRA 6'b000011, SRL 6'b000010, NOR 6'b100111), shared with the ALU and the bench.
- Sub-module `uart_alu_if_timer`: the timeout counter, instantiated only under the macro.

## Test plan
- Reset released, rx bytes 0x05, 0x03, 0x20 with the bench ALU model → `o_alu_op`=6'b100000, `o_tx_data`=0x08, `o_tx_start` one pulse exactly 2 cycles after the opcode edge.
- Bytes 0x03, 0x05, 0xE2 → `o_alu_op`=6'b100010 (upper bits dropped), `o_tx_data`=0xFE.
- Extra byte 0xAA pulsed during WAIT_TX → ignored; the next frame 0x0F, 0xF0, 0x25 yields 0xFF (OR), `o_alu_data_a` loaded with 0x0F, not 0xAA.
- `i_reset` low during WAIT_TX → all outputs 0 immediately; after release the next three bytes form a fresh frame.
- With `UART_ALU_IF_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100: send A only, wait 100 cycles → `o_timeout` one pulse, state WAIT_A, no `o_tx_start`.
- Same configuration, B valid on the expiry cycle → no timeout, WAIT_OP entered. Without the macro, the same idle gap leaves the block in WAIT_B and `o_timeout` stays 0.

Source files
------------

// File: rtl/uart_alu_pkg.sv
// uart_alu_pkg: shared types and constants for the UART/ALU byte controller, the ALU and the bench.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_alu_pkg;

   // Default widths of the UART byte path and the ALU opcode.
   localparam int NB_DATA_DEF = 8;
   localparam int NB_OP_DEF   = 6;

   // Controller sequencing states: collect A, B, opcode, then latch, send and wait for tx.
   typedef enum logic [2:0] {
      WAIT_A  = 3'd0,
      WAIT_B  = 3'd1,
      WAIT_OP = 3'd2,
      LATCH   = 3'd3,
      SEND    = 3'd4,
      WAIT_TX = 3'd5
   } state_t;

   // ALU opcodes (MIPS funct-style encoding), shared with the ALU and the bench.
   localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'b100000;
   localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'b100010;
   localparam logic [NB_OP_DEF-1:0] OP_AND = 6'b100100;
   localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'b100101;
   localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'b100110;
   localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'b000011;
   localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'b000010;
   localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'b100111;

   // True while a frame is still being collected byte by byte; the timeout only applies here.
   function automatic logic is_byte_wait(input state_t s);
      return (s == WAIT_B) || (s == WAIT_OP);
   endfunction

endpackage

// File: rtl/uart_alu_if_timer.sv
// uart_alu_if_timer: inter-byte timeout counter for the UART/ALU controller.
// Latency: o_expired is combinational, asserted in the cycle the count reaches TIMEOUT_CYCLES-1.
// Backpressure: none; a valid byte in the expiry cycle suppresses expiry and restarts the count.
module uart_alu_if_timer #(
   parameter int TIMEOUT_CYCLES = 1_000_000,
   parameter int NB_TIMEOUT     = $clog2(TIMEOUT_CYCLES)
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_run,
   input  logic i_rx_data_valid,
   output logic o_expired
);

   localparam logic [NB_TIMEOUT-1:0] LAST_COUNT = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

   logic [NB_TIMEOUT-1:0] count;

   // An incoming byte wins over expiry, so expiry requires a quiet cycle.
   assign o_expired = i_run && !i_rx_data_valid && (count == LAST_COUNT);

   // Count idle cycles while waiting for a byte; held at zero outside the wait states so
   // every entry into WAIT_B starts from zero, and cleared by each accepted byte.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         count <= '0;
      end else if (!i_run || i_rx_data_valid || o_expired) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/uart_alu_interface.sv
// uart_alu_interface: collects A, B, opcode bytes from UART rx, drives the ALU, launches tx of the result.
// Latency: o_tx_data captured 1 cycle and o_tx_start pulsed 2 cycles after the opcode byte edge.
// Backpressure: none; rx bytes while busy are dropped. Optional inter-byte timeout: UART_ALU_IF_TIMEOUT_EN.
module uart_alu_interface
   import uart_alu_pkg::*;
#(
   parameter int NB_DATA        = NB_DATA_DEF,
   parameter int NB_OP          = NB_OP_DEF,
   parameter int TIMEOUT_CYCLES = 1_000_000,
   parameter int NB_TIMEOUT     = $clog2(TIMEOUT_CYCLES)
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_rx_data_valid,
   input  logic               i_tx_done,
   input  logic [NB_DATA-1:0] i_alu_result,
   output logic [NB_DATA-1:0] o_alu_data_a,
   output logic [NB_DATA-1:0] o_alu_data_b,
   output logic [NB_OP-1:0]   o_alu_op,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_tx_start,
   output logic               o_busy,
   output logic               o_timeout
);

   state_t state;
   state_t state_next;
   logic   busy;
   logic   expired;

`ifdef UART_ALU_IF_TIMEOUT_EN
   logic timeout_q;

   uart_alu_if_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .NB_TIMEOUT     (NB_TIMEOUT)
   ) u_timer (
      .i_clock         (i_clock),
      .i_reset         (i_reset),
      .i_run           (is_byte_wait(state)),
      .i_rx_data_valid (i_rx_data_valid),
      .o_expired       (expired)
   );

   // Registered abort pulse: high for the cycle after the frame is dropped back to WAIT_A.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= expired;
      end
   end

   assign o_timeout = timeout_q;
`else
   // No timer: wait forever for the next byte. The timeout parameters are folded here only
   // so that the default build carries no dangling configuration.
   logic [NB_TIMEOUT-1:0] unused_timeout_cfg;
   assign unused_timeout_cfg = NB_TIMEOUT'(TIMEOUT_CYCLES);
   assign expired            = 1'b0;
   assign o_timeout          = 1'b0;
`endif

   // State register; reset drops any frame in progress, including one mid-transmission.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state <= WAIT_A;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and busy decode. Bytes outside the three wait states and tx_done outside
   // WAIT_TX fall through unhandled, which is how they are dropped.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      case (state)
         WAIT_A: begin
            if (i_rx_data_valid) state_next = WAIT_B;
         end
         WAIT_B: begin
            if (i_rx_data_valid)  state_next = WAIT_OP;
            else if (expired)     state_next = WAIT_A;
         end
         WAIT_OP: begin
            if (i_rx_data_valid)  state_next = LATCH;
            else if (expired)     state_next = WAIT_A;
         end
         LATCH: begin
            busy       = 1'b1;
            state_next = SEND;
         end
         SEND: begin
            busy       = 1'b1;
            state_next = WAIT_TX;
         end
         WAIT_TX: begin
            busy = 1'b1;
            if (i_tx_done) state_next = WAIT_A;
         end
         default: begin
            state_next = WAIT_A;
         end
      endcase
   end

   assign o_busy = busy;

   // Operand/opcode capture, result capture and the tx request. Operands persist across
   // aborted frames. The ALU settles during the LATCH cycle before its result is captured,
   // and the start pulse is registered from SEND so it lands 2 cycles after the opcode edge.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         o_alu_data_a <= '0;
         o_alu_data_b <= '0;
         o_alu_op     <= '0;
         o_tx_data    <= '0;
         o_tx_start   <= 1'b0;
      end else begin
         if (state == WAIT_A && i_rx_data_valid)  o_alu_data_a <= i_rx_data;
         if (state == WAIT_B && i_rx_data_valid)  o_alu_data_b <= i_rx_data;
         if (state == WAIT_OP && i_rx_data_valid) o_alu_op     <= i_rx_data[NB_OP-1:0];
         if (state == LATCH)                      o_tx_data    <= i_alu_result;
         o_tx_start <= (state == SEND);
      end
   end

endmodule

// File: tb/tb_uart_alu_interface.sv
// tb_uart_alu_interface: directed bench for uart_alu_interface with an ALU model and a timed scoreboard.
// Latency: expects o_tx_start 2 cycles after the opcode edge and o_timeout 1 cycle after expiry.
// Backpressure: exercises dropped bytes while busy; timeout cases depend on UART_ALU_IF_TIMEOUT_EN.
module tb_uart_alu_interface;
   import uart_alu_pkg::*;

   localparam int TO_CYC = 100;

   logic       tb_i_clock;
   logic       tb_i_reset;
   logic [7:0] tb_i_rx_data;
   logic       tb_i_rx_data_valid;
   logic       tb_i_tx_done;
   logic [7:0] tb_i_alu_result;
   logic [7:0] tb_o_alu_data_a;
   logic [7:0] tb_o_alu_data_b;
   logic [5:0] tb_o_alu_op;
   logic [7:0] tb_o_tx_data;
   logic       tb_o_tx_start;
   logic       tb_o_busy;
   logic       tb_o_timeout;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [5:0] op;
      logic [7:0] res;
      time        t;
   } exp_t;

   exp_t q_tx[$];
   time  q_to[$];
   time  t_last;

   uart_alu_interface #(
      .NB_DATA        (8),
      .NB_OP          (6),
      .TIMEOUT_CYCLES (TO_CYC)
   ) dut (
      .i_clock         (tb_i_clock),
      .i_reset         (tb_i_reset),
      .i_rx_data       (tb_i_rx_data),
      .i_rx_data_valid (tb_i_rx_data_valid),
      .i_tx_done       (tb_i_tx_done),
      .i_alu_result    (tb_i_alu_result),
      .o_alu_data_a    (tb_o_alu_data_a),
      .o_alu_data_b    (tb_o_alu_data_b),
      .o_alu_op        (tb_o_alu_op),
      .o_tx_data       (tb_o_tx_data),
      .o_tx_start      (tb_o_tx_start),
      .o_busy          (tb_o_busy),
      .o_timeout       (tb_o_timeout)
   );

   function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [5:0] op);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_SRA:  return 8'($signed(a) >>> b);
         OP_SRL:  return a >> b;
         OP_NOR:  return ~(a | b);
         default: return 8'h00;
      endcase
   endfunction

   always_comb tb_i_alu_result = alu_model(tb_o_alu_data_a, tb_o_alu_data_b, tb_o_alu_op);

   initial tb_i_clock = 1'b0;
   always #5 tb_i_clock = ~tb_i_clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // One byte: valid driven at a falling edge, sampled by the next rising edge.
   task automatic rx(input logic [7:0] b);
      @(negedge tb_i_clock);
      tb_i_rx_data       = b;
      tb_i_rx_data_valid = 1'b1;
      t_last             = $time;
      @(negedge tb_i_clock);
      tb_i_rx_data_valid = 1'b0;
   endtask

   // The opcode byte driven at t_last is sampled 5 ns later; tx_start is seen 2 cycles on.
   task automatic push_exp(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb);
      exp_t e;
      e.a   = a;
      e.b   = b;
      e.op  = opb[5:0];
      e.res = alu_model(a, b, opb[5:0]);
      e.t   = t_last + 30;
      q_tx.push_back(e);
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb);
      rx(a);
      rx(b);
      rx(opb);
      push_exp(a, b, opb);
   endtask

   task automatic wait_start();
      int k;
      k = 0;
      while (!tb_o_tx_start && k < 20) begin
         @(negedge tb_i_clock);
         k++;
      end
      check("tx_start_seen", 32'(tb_o_tx_start), 32'd1);
      check("busy_at_start", 32'(tb_o_busy), 32'd1);
   endtask

   task automatic tx_done();
      @(negedge tb_i_clock);
      tb_i_tx_done = 1'b1;
      @(negedge tb_i_clock);
      tb_i_tx_done = 1'b0;
      check("busy_after_done", 32'(tb_o_busy), 32'd0);
   endtask

   // Per-cycle comparison against the scoreboard of expected tx launches and timeouts.
   always @(negedge tb_i_clock) begin
      bit   exp_start;
      bit   exp_to;
      exp_t e;
      exp_start = (q_tx.size() > 0) && (q_tx[0].t == $time);
      exp_to    = (q_to.size() > 0) && (q_to[0] == $time);
      check("tx_start", 32'(tb_o_tx_start), 32'(exp_start));
      check("timeout", 32'(tb_o_timeout), 32'(exp_to));
      if (exp_start) begin
         e = q_tx[0];
         check("tx_data", 32'(tb_o_tx_data), 32'(e.res));
         check("alu_op", 32'(tb_o_alu_op), 32'(e.op));
         check("alu_a", 32'(tb_o_alu_data_a), 32'(e.a));
         check("alu_b", 32'(tb_o_alu_data_b), 32'(e.b));
      end
      while (q_tx.size() > 0 && q_tx[0].t <= $time) void'(q_tx.pop_front());
      while (q_to.size() > 0 && q_to[0] <= $time) void'(q_to.pop_front());
   end

   initial begin
      #500000;
      n_tests++;
      n_fail++;
      $display("[TB] FAIL watchdog: simulation did not complete, expected finish before 500000");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      logic [7:0] vec [3][4];
      vec[0] = '{8'h5A, 8'h0F, 8'h26, 8'h55};
      vec[1] = '{8'hCC, 8'hAA, 8'h24, 8'h88};
      vec[2] = '{8'h07, 8'h02, 8'h27, 8'hF8};

      tb_i_reset         = 1'b1;
      tb_i_rx_data       = 8'h00;
      tb_i_rx_data_valid = 1'b0;
      tb_i_tx_done       = 1'b0;
      #1 tb_i_reset = 1'b0;

      // Reset state.
      @(negedge tb_i_clock);
      check("rst_alu_a", 32'(tb_o_alu_data_a), 32'h0);
      check("rst_alu_b", 32'(tb_o_alu_data_b), 32'h0);
      check("rst_alu_op", 32'(tb_o_alu_op), 32'h0);
      check("rst_tx_data", 32'(tb_o_tx_data), 32'h0);
      check("rst_busy", 32'(tb_o_busy), 32'h0);
      @(negedge tb_i_clock);
      tb_i_reset = 1'b1;

      // ADD frame: opcode visible and busy right after the opcode edge.
      send_frame(8'h05, 8'h03, 8'h20);
      check("f1_op", 32'(tb_o_alu_op), 32'b100000);
      check("f1_busy", 32'(tb_o_busy), 32'd1);
      wait_start();
      check("f1_tx_data", 32'(tb_o_tx_data), 32'h08);
      tx_done();

      // SUB with upper opcode bits set.
      send_frame(8'h03, 8'h05, 8'hE2);
      check("f2_op", 32'(tb_o_alu_op), 32'b100010);
      wait_start();
      check("f2_tx_data", 32'(tb_o_tx_data), 32'hFE);
      tx_done();

      // Table of further operations with hand results.
      for (int i = 0; i < 3; i++) begin
         send_frame(vec[i][0], vec[i][1], vec[i][2]);
         wait_start();
         check("tbl_tx_data", 32'(tb_o_tx_data), 32'(vec[i][3]));
         tx_done();
      end

      // Byte during WAIT_TX is dropped; next frame starts cleanly.
      send_frame(8'h11, 8'h22, 8'h20);
      wait_start();
      rx(8'hAA);
      check("drop_alu_a", 32'(tb_o_alu_data_a), 32'h11);
      tx_done();
      send_frame(8'h0F, 8'hF0, 8'h25);
      check("or_alu_a", 32'(tb_o_alu_data_a), 32'h0F);
      wait_start();
      check("or_tx_data", 32'(tb_o_tx_data), 32'hFF);
      tx_done();

      // Asynchronous reset while the start pulse is high.
      send_frame(8'h40, 8'h01, 8'h02);
      wait_start();
      #2 tb_i_reset = 1'b0;
      #1;
      check("arst_alu_a", 32'(tb_o_alu_data_a), 32'h0);
      check("arst_alu_b", 32'(tb_o_alu_data_b), 32'h0);
      check("arst_alu_op", 32'(tb_o_alu_op), 32'h0);
      check("arst_tx_data", 32'(tb_o_tx_data), 32'h0);
      check("arst_tx_start", 32'(tb_o_tx_start), 32'h0);
      check("arst_busy", 32'(tb_o_busy), 32'h0);
      check("arst_timeout", 32'(tb_o_timeout), 32'h0);
      @(negedge tb_i_clock);
      tb_i_reset = 1'b1;
      send_frame(8'h06, 8'h07, 8'h20);
      wait_start();
      check("post_rst_tx_data", 32'(tb_o_tx_data), 32'h0D);
      tx_done();

      // A only, then a 110-cycle idle gap.
      rx(8'h09);
`ifdef UART_ALU_IF_TIMEOUT_EN
      q_to.push_back(t_last + 10 * TO_CYC + 10);
`endif
      repeat (110) @(negedge tb_i_clock);
`ifdef UART_ALU_IF_TIMEOUT_EN
      send_frame(8'h10, 8'h07, 8'h20);
      check("to_fresh_alu_a", 32'(tb_o_alu_data_a), 32'h10);
      wait_start();
      check("to_fresh_tx_data", 32'(tb_o_tx_data), 32'h17);
`else
      rx(8'h10);
      rx(8'h20);
      push_exp(8'h09, 8'h10, 8'h20);
      check("nto_alu_a", 32'(tb_o_alu_data_a), 32'h09);
      wait_start();
      check("nto_tx_data", 32'(tb_o_tx_data), 32'h19);
`endif
      tx_done();

      // B arrives on the expiry cycle: accepted, no timeout.
      rx(8'hF0);
      repeat (TO_CYC - 2) @(negedge tb_i_clock);
      rx(8'h03);
      rx(8'h83);
      push_exp(8'hF0, 8'h03, 8'h83);
      check("edge_op", 32'(tb_o_alu_op), 32'b000011);
      wait_start();
      check("edge_tx_data", 32'(tb_o_tx_data), 32'hFE);
      tx_done();

      repeat (5) @(negedge tb_i_clock);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
